io_mux_sequencer: RTL

//  Break-before-make controller for one io_mux pin. Accepts function-change requests

---
 rtl/io_mux_sequencer_pkg.sv | 33 +++
 rtl/io_mux_sequencer_guard_counter.sv | 46 ++++
 rtl/io_mux_sequencer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/io_mux_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// io_mux_sequencer_pkg
//   Shared definitions for the io_mux break-before-make sequencer:
//   FSM state encodings plus width helpers for the function select and the
//   guard counter.
// -----------------------------------------------------------------------------
package io_mux_sequencer_pkg;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_SWITCH = 2'd2;
  localparam logic [1:0] ST_SETTLE = 2'd3;

  // Width of a function select; a single-function pin still gets a 1-bit bus
  function automatic int fwidth_f(input int fcount);
    if (fcount <= 2) begin
      return 1;
    end else begin
      return $clog2(fcount);
    end
  endfunction

  // Width of a counter that must hold the value guard
  function automatic int cwidth_f(input int guard);
    if (guard <= 1) begin
      return 1;
    end else begin
      return $clog2(guard + 1);
    end
  endfunction

endpackage

// File: rtl/io_mux_sequencer_guard_counter.sv
// -----------------------------------------------------------------------------
// io_mux_sequencer_guard_counter
//   Loadable down-counter timing the tristate guard phases. Loads GUARD_CYCLES
//   on reset or i_load, then counts down and saturates at zero.
//   o_expired is high in the last cycle of a phase (count <= 1), so a phase
//   that starts with a load lasts exactly GUARD_CYCLES cycles.
// Ports
//   i_clk      clock
//   i_rst      synchronous active-high reset (loads GUARD_CYCLES)
//   i_load     reload GUARD_CYCLES at the next edge
//   o_expired  current cycle is the final cycle of the phase
// -----------------------------------------------------------------------------
module io_mux_sequencer_guard_counter
  import io_mux_sequencer_pkg::*;
#(
  parameter int GUARD_CYCLES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  output logic o_expired
);

  localparam int CW = cwidth_f(GUARD_CYCLES);
  localparam logic [CW-1:0] LOAD_VAL = CW'(GUARD_CYCLES);
  localparam logic [CW-1:0] ONE      = CW'(1'b1);
  localparam logic [CW-1:0] ZERO     = {CW{1'b0}};

  logic [CW-1:0] r_count;

  // Down-counter: reload on reset/load, otherwise decrement and hold at zero
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= LOAD_VAL;
    end else if (i_load) begin
      r_count <= LOAD_VAL;
    end else if (r_count != ZERO) begin
      r_count <= r_count - ONE;
    end else begin
      r_count <= r_count;
    end
  end

  assign o_expired = (r_count <= ONE);

endmodule

// File: rtl/io_mux_sequencer.sv
// -----------------------------------------------------------------------------
// io_mux_sequencer
//   Break-before-make controller for one io_mux pin. Function-change requests
//   arrive on a valid/ready handshake; the pin is tristated and receive data is
//   blocked for GUARD_CYCLES before and after the select changes.
// Ports
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_req_valid       request to change function
//   i_req_func        requested function select (sampled only on transfer)
//   o_req_ready       high only in IDLE
//   o_done            1-cycle pulse: accepted request completed (incl. no-op)
//   o_req_error       1-cycle pulse: accepted request out of range, rejected
//   o_busy            sequencer not IDLE
//   o_mux_select      to io_mux func_select
//   o_out_en_mask     gate for io_mux pin_ena
//   o_rx_valid        gate for io_mux func_receive bits
// -----------------------------------------------------------------------------
module io_mux_sequencer
  import io_mux_sequencer_pkg::*;
#(
  parameter int RXCOUNT      = 1,
  parameter int TXCOUNT      = 1,
  parameter int GUARD_CYCLES = 2,
  parameter int DEFAULT_FUNC = 0
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst,
  input  logic                                   i_req_valid,
  input  logic [fwidth_f(RXCOUNT+TXCOUNT)-1:0]   i_req_func,
  output logic                                   o_req_ready,
  output logic                                   o_done,
  output logic                                   o_req_error,
  output logic                                   o_busy,
  output logic [fwidth_f(RXCOUNT+TXCOUNT)-1:0]   o_mux_select,
  output logic                                   o_out_en_mask,
  output logic                                   o_rx_valid
);

  localparam int FCOUNT = RXCOUNT + TXCOUNT;
  localparam int FWIDTH = fwidth_f(FCOUNT);
  localparam int FW1    = FWIDTH + 1;
  localparam logic [FWIDTH:0]   FCOUNT_V    = FW1'(FCOUNT);
  localparam logic [FWIDTH-1:0] DEFAULT_SEL = FWIDTH'(DEFAULT_FUNC);

  logic [1:0]        r_state;
  logic [FWIDTH-1:0] r_sel;
  logic [FWIDTH-1:0] r_target;
  logic              r_pending;   // a real switch is in flight and owes a done
  logic              r_done;
  logic              r_err;
  logic              r_ready;
  logic              r_busy;
  logic              r_oen;
  logic              r_rxv;

  logic [1:0]        w_state_nxt;
  logic [FWIDTH-1:0] w_sel_nxt;
  logic [FWIDTH-1:0] w_target_nxt;
  logic              w_pending_nxt;
  logic              w_done_nxt;
  logic              w_err_nxt;
  logic              w_load;
  logic              w_expired;

  io_mux_sequencer_guard_counter #(
    .GUARD_CYCLES (GUARD_CYCLES)
  ) u_guard (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_load    (w_load),
    .o_expired (w_expired)
  );

  // Next-state and next-output decode for the break-before-make sequence
  always_comb begin
    w_state_nxt   = r_state;
    w_sel_nxt     = r_sel;
    w_target_nxt  = r_target;
    w_pending_nxt = r_pending;
    w_done_nxt    = 1'b0;
    w_err_nxt     = 1'b0;
    w_load        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_req_valid) begin
          if ({1'b0, i_req_func} >= FCOUNT_V) begin
            w_err_nxt = 1'b1;
          end else if (i_req_func == r_sel) begin
            // Same function already selected: complete without tristating
            w_done_nxt = 1'b1;
          end else begin
            w_target_nxt  = i_req_func;
            w_pending_nxt = 1'b1;
            w_state_nxt   = ST_DRAIN;
            w_load        = 1'b1;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (w_expired) begin
          // Select changes at the edge into SWITCH, so it is live during SWITCH
          w_sel_nxt   = r_target;
          w_state_nxt = ST_SWITCH;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_SWITCH: begin
        w_state_nxt = ST_SETTLE;
        w_load      = 1'b1;
      end
      ST_SETTLE: begin
        if (w_expired) begin
          // The post-reset settle has no pending request, hence no done
          w_state_nxt   = ST_IDLE;
          w_done_nxt    = r_pending;
          w_pending_nxt = 1'b0;
        end else begin
          w_state_nxt = ST_SETTLE;
        end
      end
      default: begin
        w_state_nxt   = ST_SETTLE;
        w_pending_nxt = 1'b0;
        w_load        = 1'b1;
      end
    endcase
  end

  // State and registered outputs; outputs are decoded from the next state
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_SETTLE;
      r_sel     <= DEFAULT_SEL;
      r_target  <= DEFAULT_SEL;
      r_pending <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_ready   <= 1'b0;
      r_busy    <= 1'b1;
      r_oen     <= 1'b0;
      r_rxv     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_sel     <= w_sel_nxt;
      r_target  <= w_target_nxt;
      r_pending <= w_pending_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
      r_ready   <= (w_state_nxt == ST_IDLE);
      r_busy    <= (w_state_nxt != ST_IDLE);
      r_oen     <= (w_state_nxt == ST_IDLE);
      r_rxv     <= (w_state_nxt == ST_IDLE);
    end
  end

  assign o_req_ready   = r_ready;
  assign o_done        = r_done;
  assign o_req_error   = r_err;
  assign o_busy        = r_busy;
  assign o_mux_select  = r_sel;
  assign o_out_en_mask = r_oen;
  assign o_rx_valid    = r_rxv;

endmodule
